// File: rtl/fp_pkg.sv
// Shared constants and types for the pipelined floating-point adder.
// Widths here are the defaults; fpadd_pipe derives its own from EXP_W/MAN_W.
package fp_pkg;

  localparam int unsigned FP_EXP_W = 8;
  localparam int unsigned FP_MAN_W = 23;
  localparam int unsigned FP_W     = 1 + FP_EXP_W + FP_MAN_W;
  localparam int unsigned FP_XW    = FP_MAN_W + 4;  // hidden + mantissa + G/R/S
  localparam int unsigned FP_SW    = FP_MAN_W + 5;  // carry + FP_XW

  localparam logic [FP_W-1:0] FP_ZERO = '0;
  localparam logic [FP_W-1:0] FP_NAN  = '1;

  typedef struct packed {
    logic                sign;
    logic [FP_EXP_W-1:0] exp;
    logic [FP_MAN_W-1:0] mant;
  } fp_op_t;

endpackage

// File: rtl/fpadd_pipe_if.sv
// Operand/result handshake bundle for fpadd_pipe.
// master drives operands and out_ready; slave is the adder.
interface fpadd_pipe_if
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = FP_EXP_W,
  parameter int unsigned MAN_W = FP_MAN_W
);
  localparam int unsigned W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] z;
  logic         ovf;
  logic         unf;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, z, ovf, unf
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, z, ovf, unf
  );
endinterface

// File: rtl/fpadd_lzc.sv
// Leading-zero counter; returns WIDTH when the input is all zeros.
module fpadd_lzc #(
  parameter int unsigned WIDTH = 28,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] value,
  output logic [CNT_W-1:0] count
);

  // Ascending scan: the highest set bit is the last one to write count.
  always_comb begin
    count = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (value[i]) count = CNT_W'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/fpadd_pipe.sv
// Three-stage floating-point adder (align / add / normalise+pack) with a global stall.
// Define FPADD_RNE_EN for round-to-nearest-even; otherwise results are truncated.
module fpadd_pipe
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = FP_EXP_W,
  parameter int unsigned MAN_W = FP_MAN_W
) (
  input logic         clk,
  input logic         rst_n,
  fpadd_pipe_if.slave bus
);

  localparam int unsigned W    = 1 + EXP_W + MAN_W;
  localparam int unsigned XW   = MAN_W + 4;
  localparam int unsigned SW   = MAN_W + 5;
  localparam int unsigned EW   = EXP_W + 2;
  localparam int unsigned LW   = $clog2(SW + 1);
  localparam int          EMAX = (1 << EXP_W) - 1;

  logic stall, en;
  assign stall        = bus.out_valid && !bus.out_ready;
  assign en           = !stall;
  assign bus.in_ready = en;

  // ---------------- S1: unpack, swap, align ----------------
  logic [EXP_W-1:0] ea, eb, e_big, e_small, ediff;
  logic [XW-1:0]    xa, xb, x_big, x_small, x_al;
  logic [2*XW-1:0]  sh;
  logic             s_big, s_small, nan_in;
  int unsigned      sh_amt;

  always_comb begin
    ea     = bus.a[W-2:MAN_W];
    eb     = bus.b[W-2:MAN_W];
    xa     = (ea == '0) ? '0 : {1'b1, bus.a[MAN_W-1:0], 3'b000};
    xb     = (eb == '0) ? '0 : {1'b1, bus.b[MAN_W-1:0], 3'b000};
    nan_in = (ea == '1) || (eb == '1);
    if ({ea, xa} >= {eb, xb}) begin
      s_big = bus.a[W-1]; e_big = ea; x_big = xa;
      s_small = bus.b[W-1]; e_small = eb; x_small = xb;
    end else begin
      s_big = bus.b[W-1]; e_big = eb; x_big = xb;
      s_small = bus.a[W-1]; e_small = ea; x_small = xa;
    end
    ediff  = e_big - e_small;
    // Beyond XW positions everything lands in the lower half and becomes sticky.
    sh_amt = (32'(ediff) > XW) ? XW : 32'(ediff);
    sh     = {x_small, {XW{1'b0}}} >> sh_amt;
    x_al   = sh[2*XW-1:XW] | {{(XW-1){1'b0}}, |sh[XW-1:0]};
  end

  logic             s1_valid_q, s1_sign_q, s1_sub_q, s1_nan_q;
  logic [EXP_W-1:0] s1_exp_q;
  logic [XW-1:0]    s1_ma_q, s1_mb_q;

  // ---------------- S2: add / subtract ----------------
  logic             s2_valid_q, s2_sign_q, s2_nan_q;
  logic [EXP_W-1:0] s2_exp_q;
  logic [SW-1:0]    s2_sum_q, sum_d;

  assign sum_d = s1_sub_q ? ({1'b0, s1_ma_q} - {1'b0, s1_mb_q})
                          : ({1'b0, s1_ma_q} + {1'b0, s1_mb_q});

  // ---------------- S3: normalise, round, pack ----------------
  logic [LW-1:0]          lzc;
  logic [SW-1:0]          shl;
  logic [XW-1:0]          norm;
  logic signed [EW-1:0]   exp_n;
  logic [MAN_W+1:0]       mant_r;
  logic [MAN_W-1:0]       frac;
  logic [W-1:0]           z_d;
  logic                   ovf_d, unf_d;

  fpadd_lzc #(.WIDTH(SW)) u_lzc (
    .value (s2_sum_q),
    .count (lzc)
  );

`ifndef FPADD_RNE_EN
  logic unused_grs;
  assign unused_grs = ^norm[2:0];
`endif

  always_comb begin
    exp_n = $signed({2'b00, s2_exp_q});
    shl   = s2_sum_q << (lzc - LW'(1));
    if (s2_sum_q[SW-1]) begin
      norm  = {s2_sum_q[SW-1:2], s2_sum_q[1] | s2_sum_q[0]};
      exp_n = exp_n + EW'(1);
    end else begin
      norm  = shl[XW-1:0];
      exp_n = exp_n + EW'(1) - EW'(lzc);
    end
`ifdef FPADD_RNE_EN
    mant_r = {1'b0, norm[XW-1:3]}
           + (MAN_W+2)'(norm[2] & (norm[1] | norm[0] | norm[3]));
`else
    mant_r = {1'b0, norm[XW-1:3]};
`endif
    frac = mant_r[MAN_W+1] ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];
    if (mant_r[MAN_W+1]) exp_n = exp_n + EW'(1);

    z_d   = {s2_sign_q, exp_n[EXP_W-1:0], frac};
    ovf_d = 1'b0;
    unf_d = 1'b0;
    if (s2_nan_q) begin
      z_d   = '1;
      ovf_d = 1'b1;
    end else if (s2_sum_q == '0) begin
      z_d = '0;
    end else if (exp_n <= 0) begin
      z_d   = '0;
      unf_d = 1'b1;
    end else if (exp_n >= EMAX) begin
      z_d   = '1;
      ovf_d = 1'b1;
    end
  end

  logic         out_valid_q, ovf_q, unf_q;
  logic [W-1:0] z_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_sub_q    <= 1'b0;
      s1_nan_q    <= 1'b0;
      s1_exp_q    <= '0;
      s1_ma_q     <= '0;
      s1_mb_q     <= '0;
      s2_valid_q  <= 1'b0;
      s2_sign_q   <= 1'b0;
      s2_nan_q    <= 1'b0;
      s2_exp_q    <= '0;
      s2_sum_q    <= '0;
      out_valid_q <= 1'b0;
      z_q         <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else if (en) begin
      s1_valid_q  <= bus.in_valid;
      s1_sign_q   <= s_big;
      s1_sub_q    <= s_big ^ s_small;
      s1_nan_q    <= nan_in;
      s1_exp_q    <= e_big;
      s1_ma_q     <= x_big;
      s1_mb_q     <= x_al;
      s2_valid_q  <= s1_valid_q;
      s2_sign_q   <= s1_sign_q;
      s2_nan_q    <= s1_nan_q;
      s2_exp_q    <= s1_exp_q;
      s2_sum_q    <= sum_d;
      out_valid_q <= s2_valid_q;
      z_q         <= z_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.z         = z_q;
  assign bus.ovf       = ovf_q;
  assign bus.unf       = unf_q;

endmodule
